// File: rtl/pn_checker.sv
// ---------------------------------------------------------------------------
// pn_checker
//
// Synchronises to and monitors a bit stream from the team's 7-stage PN
// generator, s(n) = s(n-7) ^ s(n-4) ^ s(n-3) ^ s(n-2).
//
// Acquisition runs SEARCH -> VERIFY -> LOCKED.
// - SEARCH fills a 7-bit history from the line.
// - VERIFY requires LOCK_CNT consecutive correct predictions.
// - LOCKED free-runs the history from its own predictions, so that line
//   errors are counted but never propagated. Errors are assessed in
//   windows of WIN_LEN valid bits. ERR_THR or more errors in a window
//   drops back to SEARCH.
//
// Input strobe: datain is only looked at when din_valid=1. There is no
// backpressure: every strobed bit is consumed on the edge that samples it.
//
// Ports
//   clk        : clock, all state on rising edge
//   reset_n    : asynchronous active-low reset
//   datain     : received PN bit, sampled when din_valid=1
//   din_valid  : bit strobe, any duty cycle
//   err_clr    : synchronous clear of err_cnt
//   locked     : registered, high while in LOCKED
//   bit_err    : one-cycle pulse per mismatched bit while LOCKED
//   sync_loss  : one-cycle pulse on LOCKED -> SEARCH
//   err_cnt    : saturating 16-bit count of errors seen while LOCKED
//   fsm_state  : current FSM state (0=SEARCH, 1=VERIFY, 2=LOCKED) for debug
// ---------------------------------------------------------------------------
module pn_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned WIN_LEN  = 64,
    parameter int unsigned ERR_THR  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        datain,
    input  logic        din_valid,
    input  logic        err_clr,
    output logic        locked,
    output logic        bit_err,
    output logic        sync_loss,
    output logic [15:0] err_cnt,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0]  LOCK_CNT_W = 8'(LOCK_CNT);
    localparam logic [15:0] WIN_LEN_W  = 16'(WIN_LEN);
    localparam logic [15:0] ERR_THR_W  = 16'(ERR_THR);

    logic [1:0]  state, state_nx;
    logic [7:1]  hist, hist_nx;            // hist[1] is the newest bit
    logic [2:0]  fill, fill_nx;
    logic [7:0]  match, match_nx;
    logic [15:0] win_bits, win_bits_nx;    // valid bits seen in current window
    logic [15:0] win_errs, win_errs_nx;    // errors seen in current window
    logic        pred;
    logic        err_evt;
    logic        loss_evt;
    logic [7:0]  match_inc;
    logic [15:0] win_bits_inc;
    logic [15:0] win_errs_inc;

    assign pred         = hist[7] ^ hist[4] ^ hist[3] ^ hist[2];
    assign match_inc    = match + 8'd1;
    assign win_bits_inc = win_bits + 16'd1;
    assign win_errs_inc = win_errs + {15'd0, datain ^ pred};
    assign fsm_state    = state;

    always_comb begin
        state_nx    = state;
        hist_nx     = hist;
        fill_nx     = fill;
        match_nx    = match;
        win_bits_nx = win_bits;
        win_errs_nx = win_errs;
        err_evt     = 1'b0;
        loss_evt    = 1'b0;

        if (din_valid) begin
            case (state)
                ST_SEARCH: begin
                    hist_nx = {hist[6:1], datain};
                    fill_nx = (fill == 3'd7) ? 3'd7 : fill + 3'd1;
                    // An all-zero history predicts zeros forever, so it is
                    // never allowed to proceed to verification.
                    if (fill_nx == 3'd7 && hist_nx != 7'd0) begin
                        state_nx = ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    hist_nx = {hist[6:1], datain};
                    if (datain == pred) begin
                        if (match_inc == LOCK_CNT_W) begin
                            state_nx    = ST_LOCKED;
                            match_nx    = 8'd0;
                            win_bits_nx = 16'd0;
                            win_errs_nx = 16'd0;
                        end else begin
                            match_nx = match_inc;
                        end
                    end else begin
                        // Keep the history (including this bit) so that the
                        // next valid bit can re-enter VERIFY straight away.
                        match_nx = 8'd0;
                        fill_nx  = 3'd7;
                        state_nx = ST_SEARCH;
                    end
                end

                ST_LOCKED: begin
                    // Feed back the prediction, not the line bit, so a channel
                    // error costs exactly one bit_err and no follow-on errors.
                    hist_nx = {hist[6:1], pred};
                    err_evt = datain ^ pred;
                    if (win_bits_inc == WIN_LEN_W) begin
                        win_bits_nx = 16'd0;
                        win_errs_nx = 16'd0;
                        if (win_errs_inc >= ERR_THR_W) begin
                            state_nx = ST_SEARCH;
                            fill_nx  = 3'd0;
                            loss_evt = 1'b1;
                        end
                    end else begin
                        win_bits_nx = win_bits_inc;
                        win_errs_nx = win_errs_inc;
                    end
                end

                default: begin
                    state_nx = ST_SEARCH;
                    fill_nx  = 3'd0;
                    match_nx = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SEARCH;
            hist      <= 7'd0;
            fill      <= 3'd0;
            match     <= 8'd0;
            win_bits  <= 16'd0;
            win_errs  <= 16'd0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            sync_loss <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill      <= fill_nx;
            match     <= match_nx;
            win_bits  <= win_bits_nx;
            win_errs  <= win_errs_nx;
            locked    <= (state_nx == ST_LOCKED);
            bit_err   <= err_evt;
            sync_loss <= loss_evt;
            // A clear coinciding with an error leaves that error counted.
            if (err_clr) begin
                err_cnt <= {15'd0, err_evt};
            end else if (err_evt && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/pn_checker.md
PN_CHECKER -- requirements
Module: pn_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive correct predictions in VERIFY needed to declare lock (range 1..255).
REQ-002 SHALL have parameter WIN_LEN, default 64: bits per error-monitoring window in LOCKED (range 2..65535).
REQ-003 SHALL have parameter ERR_THR, default 8: errors within one window that force loss of sync (range 1..WIN_LEN).
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port datain, input, 1: received PN bit, sampled only when din_valid=1.
REQ-007 SHALL have port din_valid, input, 1: bit strobe, any duty cycle, including continuous.
REQ-008 SHALL have port err_clr, input, 1: synchronous clear of err_cnt.
REQ-009 SHALL have port locked, output, 1: registered, high in LOCKED state.
REQ-010 SHALL have port bit_err, output, 1: registered one-cycle pulse per mismatched bit while LOCKED.
REQ-011 SHALL have port sync_loss, output, 1: registered one-cycle pulse on LOCKED->SEARCH.
REQ-012 SHALL have port err_cnt, output, 16: saturating count of bit errors detected while LOCKED.

Function
REQ-013 SHALL check the stream of the team's 7-stage PN generator: s(n) = s(n-7)^s(n-4)^s(n-3)^s(n-2).
REQ-014 SHALL hold a 7-bit history h1..h7 (h1 newest); prediction p = h7^h4^h3^h2.
REQ-015 SHALL update state only on cycles with din_valid=1; cycles with din_valid=0 change nothing except err_clr effect and pulse deassertion.
REQ-016 SHALL implement FSM states SEARCH, VERIFY, LOCKED.
REQ-017 SEARCH: shift datain into h1, increment fill count (saturate at 7); when fill reaches 7 and new history is non-zero, go to VERIFY.
REQ-018 SEARCH with full, all-zero history: remain in SEARCH (all-zero stream never locks).
REQ-019 VERIFY: shift datain into h1; datain==p increments match count; match count reaching LOCK_CNT enters LOCKED.
REQ-020 VERIFY mismatch: clear match count, return to SEARCH with fill count = 7 (history retained, new bit included); REQ-017/018 re-evaluated on next valid bit.
REQ-021 LOCKED: history free-runs, shifting p (not datain) into h1, so single channel errors do not propagate.
REQ-022 LOCKED, datain!=p: bit_err=1 the following cycle; err_cnt +1, saturating at 65535; window error count +1.
REQ-023 LOCKED window: bit counter counts valid bits 1..WIN_LEN; at the WIN_LEN-th bit, if window errors (including that bit) >= ERR_THR, go to SEARCH with fill count 0 and pulse sync_loss; else clear both window counters and remain LOCKED.
REQ-024 Window counters SHALL be cleared on entry to LOCKED.
REQ-025 err_clr=1 SHALL zero err_cnt next edge; if an error occurs in the same cycle, err_cnt becomes 1.
REQ-026 locked SHALL rise on the edge that samples the LOCK_CNT-th match and fall on the edge that samples the failing window's last bit.
REQ-027 Outputs SHALL not be affected by datain while din_valid=0.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state SEARCH, history 0, fill/match/window counters 0, locked=0, bit_err=0, sync_loss=0, err_cnt=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort immediately; after release, acquisition restarts from empty history.

Verification
REQ-030 Clean generator stream (seed c1..c7=1001001, first bits 1,0,0,1,0,0,1), din_valid=1 continuous -> VERIFY after bit 7, locked rises on edge sampling bit 23, bit_err never asserts, err_cnt=0.
REQ-031 Locked, invert 3 isolated bits within one 64-bit window -> three bit_err pulses, err_cnt=3, locked stays 1, no sync_loss.
REQ-032 Locked, invert 8 bits in one window -> sync_loss pulse on that window's 64th bit, locked=0, then relock 23 valid bits later on clean input.
REQ-033 Constant 0 input for 200 bits -> locked stays 0; constant 1 input -> mismatch in VERIFY, never locks.
REQ-034 Clean stream with din_valid toggling 1,0,0 -> lock after 23 valid bits (edge 67), identical to REQ-030 in valid-bit terms.
REQ-035 Reset pulse while locked with err_cnt=5 -> all outputs 0 asynchronously; err_clr during error cycle -> err_cnt=1.
